// File: rtl/gen_pkg.sv
// Shared opcode encodings for the gen_alu_pipe ALU pipeline.
package gen_pkg;

  localparam int OP_W = 2;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD = 2'd0;
  localparam op_t OP_SUB = 2'd1;
  localparam op_t OP_ACC = 2'd2;
  localparam op_t OP_CLR = 2'd3;

endpackage

// File: rtl/gen_pipe_stage.sv
// Single valid/ready register slice; ready passes combinationally so a full
// chain still moves one item per cycle while the consumer is accepting.
module gen_pipe_stage #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/gen_alu_pipe.sv
// Run-time selectable add/sub/accumulate ALU feeding a STAGES-deep
// valid/ready result pipeline; the accumulator updates at accept time.
module gen_alu_pipe
  import gen_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int SAT_EN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   cout,
  output logic [WIDTH:0]   acc_o
);

  localparam int RW = WIDTH + 1;

  op_t           op_sel;
  logic          accept;
  logic [RW-1:0] a_ext, b_ext;
  logic [RW:0]   acc_sum;
  logic [RW-1:0] alu_result;
  logic [RW-1:0] acc_q, acc_d;

  logic          stg_valid [STAGES+1];
  logic          stg_ready [STAGES+1];
  logic [RW-1:0] stg_data  [STAGES+1];

  assign op_sel  = op_t'(op);
  assign a_ext   = {1'b0, a};
  assign b_ext   = {1'b0, b};
  // One extra bit so accumulator overflow is visible for saturation.
  assign acc_sum = {1'b0, acc_q} + {2'b00, a};

  always_comb begin
    alu_result = '0;
    case (op_sel)
      OP_ADD: alu_result = a_ext + b_ext;
      OP_SUB: begin
        if ((SAT_EN != 0) && (a < b)) alu_result = '0;
        else                          alu_result = a_ext - b_ext;
      end
      OP_ACC: begin
        if ((SAT_EN != 0) && acc_sum[RW]) alu_result = '1;
        else                              alu_result = acc_sum[RW-1:0];
      end
      default: alu_result = '0;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    acc_d = acc_q;
    if (accept && ((op_sel == OP_ACC) || (op_sel == OP_CLR))) acc_d = alu_result;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

  // Slot 0 is the ALU side, slot STAGES is the consumer side.
  assign stg_valid[0]      = in_valid;
  assign stg_data[0]       = alu_result;
  assign stg_ready[STAGES] = out_ready;
  assign in_ready          = stg_ready[0] && rst_n;
  assign out_valid         = stg_valid[STAGES];
  assign cout              = stg_data[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    gen_pipe_stage #(.DW(RW)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (stg_valid[k]),
      .in_ready  (stg_ready[k]),
      .in_data   (stg_data[k]),
      .out_valid (stg_valid[k+1]),
      .out_ready (stg_ready[k+1]),
      .out_data  (stg_data[k+1])
    );
  end

endmodule

// File: tb/tb_gen_alu_pipe.sv
// Directed self-checking bench for gen_alu_pipe; a wrapping and a saturating
// instance share stimulus so both arithmetic modes are checked side by side.
module tb_gen_alu_pipe;
  import gen_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       out_ready;

  logic       in_ready, out_valid;
  logic [8:0] cout, acc_o;
  logic       s_in_ready, s_out_valid;
  logic [8:0] s_cout, s_acc_o;

  int checks   = 0;
  int failures = 0;

  gen_alu_pipe #(.WIDTH(8), .STAGES(2), .SAT_EN(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cout      (cout),
    .acc_o     (acc_o)
  );

  gen_alu_pipe #(.WIDTH(8), .STAGES(2), .SAT_EN(1)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .cout      (s_cout),
    .acc_o     (s_acc_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, let the edge consume them, return 1 time unit later.
  task automatic applyStimulus(input logic v, input logic [7:0] av, input logic [7:0] bv,
                               input logic [1:0] opv);
    in_valid = v;
    a        = av;
    b        = bv;
    op       = opv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  int  next_in, next_out, buffered, cyc, got_n;
  logic prev_stall, did_acc, did_del;
  logic [8:0] prev_cout;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = OP_ADD; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_cout", 32'(cout), 0);
    checkOutput("rst_acc", 32'(acc_o), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 0);
    checkOutput("rst_sat_in_ready", 32'(s_in_ready), 0);
    rst_n = 1'b1;

    // Basic add/sub with two-cycle latency.
    applyStimulus(1, 3, 2, OP_ADD);
    checkOutput("t1_empty", 32'(out_valid), 0);
    applyStimulus(1, 255, 255, OP_ADD);
    checkOutput("t1_add_valid", 32'(out_valid), 1);
    checkOutput("t1_add", 32'(cout), 5);
    applyStimulus(1, 10, 4, OP_SUB);
    checkOutput("t1_add_max", 32'(cout), 510);
    applyStimulus(0, 0, 0, OP_ADD);
    checkOutput("t1_sub", 32'(cout), 6);
    applyStimulus(0, 0, 0, OP_ADD);
    checkOutput("t1_drained", 32'(out_valid), 0);

    // Underflowing subtract: wrap vs clamp.
    applyStimulus(1, 2, 3, OP_SUB);
    applyStimulus(0, 0, 0, OP_ADD);
    checkOutput("t2_sub_wrap", 32'(cout), 511);
    checkOutput("t2_sat_valid", 32'(s_out_valid), 1);
    checkOutput("t2_sub_sat", 32'(s_cout), 0);
    applyStimulus(0, 0, 0, OP_ADD);

    // Accumulator chain, then overflow from 500.
    applyStimulus(1, 0, 0, OP_CLR);
    applyStimulus(1, 10, 99, OP_ACC);
    checkOutput("t3_clr", 32'(cout), 0);
    applyStimulus(1, 20, 0, OP_ACC);
    checkOutput("t3_acc10", 32'(cout), 10);
    applyStimulus(1, 30, 0, OP_ACC);
    checkOutput("t3_acc30", 32'(cout), 30);
    checkOutput("t3_acc_o60", 32'(acc_o), 60);
    applyStimulus(1, 255, 0, OP_ACC);
    checkOutput("t3_acc60", 32'(cout), 60);
    applyStimulus(1, 185, 0, OP_ACC);
    checkOutput("t3_acc315", 32'(cout), 315);
    checkOutput("t3_acc_o500", 32'(acc_o), 500);
    checkOutput("t3_sat_acc_o500", 32'(s_acc_o), 500);
    applyStimulus(1, 255, 0, OP_ACC);
    checkOutput("t3_acc500", 32'(cout), 500);
    checkOutput("t3_wrap_acc_o", 32'(acc_o), 243);
    checkOutput("t3_sat_acc_o", 32'(s_acc_o), 511);
    applyStimulus(1, 255, 0, OP_ACC);
    checkOutput("t3_wrap1", 32'(cout), 243);
    checkOutput("t3_sat1", 32'(s_cout), 511);
    applyStimulus(0, 0, 0, OP_ADD);
    checkOutput("t3_wrap2", 32'(cout), 498);
    checkOutput("t3_sat2", 32'(s_cout), 511);
    checkOutput("t3_wrap_acc_o2", 32'(acc_o), 498);
    applyStimulus(0, 0, 0, OP_ADD);

    // Backpressure stream: ADD i+10, i+3 gives 2i+13.
    next_in = 1; next_out = 1; buffered = 0; cyc = 0; prev_stall = 1'b0; prev_cout = '0;
    while (next_out <= 20 && cyc < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (next_in <= 20);
      a         = 8'(next_in + 10);
      b         = 8'(next_in + 3);
      op        = OP_ADD;
      #1;
      if (prev_stall) begin
        checkOutput("t4_hold_valid", 32'(out_valid), 1);
        checkOutput("t4_hold_data", 32'(cout), 32'(prev_cout));
      end
      checkOutput("t4_in_ready", 32'(in_ready), 32'(!(buffered == 2 && !out_ready)));
      did_acc = in_valid && in_ready;
      did_del = out_valid && out_ready;
      if (did_del) begin
        checkOutput("t4_order", 32'(cout), 2 * next_out + 13);
        next_out++;
      end
      if (did_acc) next_in++;
      buffered   = buffered + int'(did_acc) - int'(did_del);
      prev_stall = out_valid && !out_ready;
      prev_cout  = cout;
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("t4_delivered", 32'(next_out), 21);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Full throughput: 50 back-to-back transfers.
    next_in = 0; got_n = 0;
    for (int c = 0; c < 60; c++) begin
      in_valid = (next_in < 50);
      a        = 8'(next_in);
      b        = 8'(next_in + 1);
      op       = OP_ADD;
      #1;
      if (in_valid) checkOutput("t5_in_ready", 32'(in_ready), 1);
      if (got_n > 0 && got_n < 50) checkOutput("t5_consecutive", 32'(out_valid), 1);
      if (out_valid && got_n < 50) begin
        checkOutput("t5_data", 32'(cout), 2 * got_n + 1);
        got_n++;
      end
      if (in_valid && in_ready) next_in++;
      @(posedge clk);
      #1;
    end
    checkOutput("t5_count", 32'(got_n), 50);
    in_valid = 1'b0;

    // Reset with two results in flight and acc=60.
    applyStimulus(1, 0, 0, OP_CLR);
    applyStimulus(1, 10, 0, OP_ACC);
    applyStimulus(1, 20, 0, OP_ACC);
    applyStimulus(1, 30, 0, OP_ACC);
    checkOutput("t6_pre_acc", 32'(acc_o), 60);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, OP_ADD);
    checkOutput("t6_rst_valid", 32'(out_valid), 0);
    checkOutput("t6_rst_cout", 32'(cout), 0);
    checkOutput("t6_rst_acc", 32'(acc_o), 0);
    checkOutput("t6_rst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, OP_ADD);
    checkOutput("t6_no_partial", 32'(out_valid), 0);
    checkOutput("t6_in_ready", 32'(in_ready), 1);
    applyStimulus(1, 7, 0, OP_ACC);
    applyStimulus(0, 0, 0, OP_ADD);
    checkOutput("t6_acc7_valid", 32'(out_valid), 1);
    checkOutput("t6_acc7", 32'(cout), 7);
    checkOutput("t6_acc_o7", 32'(acc_o), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gen_alu_pipe.md
Name: gen_alu_pipe

Overview:
- Parametrised successor to the fixed-function `gen` add/sub block.
- Operation is selected per transaction at run time instead of by a build-time parameter: add, subtract, accumulate, accumulator clear.
- Operand width and pipeline depth are parameters; optional saturation.
- Valid/ready handshake on both sides; sits between an operand source and a result consumer that may apply backpressure.

Parameters:
WIDTH, 8, operand width; results are WIDTH+1 bits.
STAGES, 2, number of result register stages (legal 1..4); latency in cycles.
SAT_EN, 0, 1 = saturating arithmetic (see Behaviour); 0 = modular wrap.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
in_valid  input  1  operand/opcode valid.
in_ready  output  1  block can accept this cycle.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
op  input  2  opcode: 0 ADD, 1 SUB, 2 ACC, 3 CLR.
out_valid  output  1  cout holds a result.
out_ready  input  1  consumer accepts this cycle.
cout  output  WIDTH+1  result.
acc_o  output  WIDTH+1  current accumulator value (registered).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all stage valid bits := 0; stage data := 0; accumulator := 0.
  - out_valid=0, cout=0, acc_o=0.
  - in_ready=0 while rst_n=0.
  - Reset mid-operation discards all in-flight results; no partial output follows reset release.
- Accept:
  - An input transfer occurs on a clk edge where in_valid && in_ready.
  - The result is computed combinationally from a, b, op and the accumulator, and loaded into stage 0.
- Arithmetic, all in WIDTH+1 bits:
  - ADD: {0,a}+{0,b}.
  - SUB: ({0,a}-{0,b}) mod 2^(WIDTH+1); bit WIDTH is the borrow.
  - ACC: acc+{0,a}; the accumulator is updated with this value at the same edge; b is ignored.
  - CLR: result 0; accumulator := 0 at the same edge.
  - ADD and SUB leave the accumulator unchanged.
- SAT_EN=1:
  - SUB clamps to 0 when a<b.
  - ACC clamps to 2^(WIDTH+1)-1 instead of wrapping.
  - ADD cannot overflow.
- SAT_EN=0:
  - ACC wraps modulo 2^(WIDTH+1).
  - Example, WIDTH=8: acc=510, a=5 -> 3.
- Pipeline:
  - STAGES register stages, each with a valid bit.
  - Stage k loads when it is empty or stage k+1 (or the output, for the last stage) accepts in the same cycle.
  - in_ready = stage 0 can load.
  - The ready path is combinational through the stages: full throughput of 1 transfer/cycle with out_ready held high.
  - Latency: a result accepted at edge N is visible on cout with out_valid=1 after edge N+STAGES-1 (STAGES=1: the cycle after acceptance).
  - Results are delivered in acceptance order.
- Backpressure:
  - While out_valid && !out_ready, cout and out_valid hold stable.
  - Upstream stages fill; in_ready falls once all STAGES are full.
  - No result is dropped or duplicated.
- Simultaneous events: output transfer and input accept in the same cycle on a full pipeline is legal and keeps the pipeline full.
- Ordering of ACC: the accumulator is updated at accept time, not at output time, so back-to-back ACC transactions chain correctly regardless of backpressure.
- acc_o reflects the accumulator register: the value after the most recent accepted ACC/CLR.
- Undefined inputs when in_valid=0 must not change state.

Decomposition:
- Shared package gen_pkg:
  - opcode localparams OP_ADD=0, OP_SUB=1, OP_ACC=2, OP_CLR=3.
  - op type width 2.
- One sub-module, gen_pipe_stage:
  - a single valid/ready register slice parametrised on data width.
  - instantiated STAGES times via generate.
- The arithmetic/accumulator front end stays in gen_alu_pipe.

Test Plan:
1. WIDTH=8, STAGES=2, out_ready=1:
   - ADD a=3,b=2 -> cout=5 two cycles later.
   - ADD a=255,b=255 -> 510.
   - SUB a=10,b=4 -> 6.
2. SUB a=2,b=3, SAT_EN=0 -> cout=511 (borrow bit set); same with SAT_EN=1 -> cout=0.
3. CLR, then ACC a=10,20,30 back-to-back:
   - cout sequence 10,30,60; acc_o=60.
   - ACC a=255 twice from 500:
     - SAT_EN=0 -> 755 mod 512 = 243, then 498.
     - SAT_EN=1 -> 511, 511.
4. Backpressure:
   - Stream ADD i+10,i+3 for i=1..20 with out_ready toggling pseudo-randomly.
   - Every result appears exactly once, in order, held stable while stalled.
   - in_ready=0 only when 2 results are buffered.
5. Full throughput: out_ready=1 and in_valid=1 for 50 cycles -> 50 results on 50 consecutive cycles after the initial latency; in_ready never drops.
6. Reset mid-stream:
   - With 2 results in flight and acc=60, assert rst_n=0 for one edge.
   - Next cycle out_valid=0, cout=0, acc_o=0.
   - After release, ACC a=7 -> cout=7.
